// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with one write port, two registered
// read ports and a bulk-clear sequencer (IDLE/CLEAR FSM).
// Optional feature macro: RF_BYPASS_EN. When defined, a read that hits the
// entry being written on the same edge returns the new value (write-first).
// When undefined, it returns the pre-write value (read-first).
//
// Clear handshake: clr_req is a single-cycle request that is accepted only
// while busy is low (FSM in IDLE). Once accepted, busy stays high for exactly
// NREGS cycles. clr_req is ignored while busy is high, and so is we.
module regfile_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NREGS   = 32,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] sel_r_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] sel_r_a,
  input  logic [ADDR_W-1:0] sel_r_b,
  output logic [DATA_W-1:0] ra,
  output logic [DATA_W-1:0] rb,
  input  logic              clr_req,
  output logic              busy
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // state is the FSM's observable state; checkers can bind to it directly.
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_start;

  logic [DATA_W-1:0] mem [NREGS];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // A selector maps to real storage only if it is below NREGS.
  function automatic logic in_range(input logic [ADDR_W-1:0] s);
    return (33'(s) < 33'(NREGS));
  endfunction

  // Readable/writable entry: in range and not the hardwired zero register.
  function automatic logic usable(input logic [ADDR_W-1:0] s);
    return in_range(s) && !((ZERO_R0 != 0) && (s == '0));
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: a clear runs from request until the last entry is zeroed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (clr_idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy flag, clear start, and the single write-port mux
  // (sequencer zero-writes own the port while clearing).
  always_comb begin
    busy      = (state == CLEAR);
    clr_start = (state == IDLE) && clr_req;
    wr_en     = 1'b0;
    wr_idx    = sel_r_in;
    wr_data   = data_in;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx;
      wr_data = '0;
    end else if (we && usable(sel_r_in)) begin
      wr_en   = 1'b1;
    end
  end

  // Clear index: restarts at 0 on acceptance, advances once per clear edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              clr_idx <= '0;
    else if (clr_start)    clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
  end

  // Storage: asynchronous zeroing on reset, one write per edge otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx[IDX_W-1:0]] <= wr_data;
    end
  end

  // Read port A data, with zero/out-of-range masking taking precedence.
  always_comb begin
    rd_a = '0;
    if (usable(sel_r_a)) begin
      rd_a = mem[sel_r_a[IDX_W-1:0]];
`ifdef RF_BYPASS_EN
      if (wr_en && (wr_idx == sel_r_a)) rd_a = wr_data;
`endif
    end
  end

  // Read port B data, same rules as port A.
  always_comb begin
    rd_b = '0;
    if (usable(sel_r_b)) begin
      rd_b = mem[sel_r_b[IDX_W-1:0]];
`ifdef RF_BYPASS_EN
      if (wr_en && (wr_idx == sel_r_b)) rd_b = wr_data;
`endif
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra <= '0;
      rb <= '0;
    end else begin
      ra <= rd_a;
      rb <= rd_b;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: randomized and directed stimulus against a behavioural
// register-file model; ZERO_R0=1, 32 entries behind 6-bit selectors so that
// selectors 32..63 are out of range.
module tb_regfile_param;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 32;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] sel_r_in;
  logic [DW-1:0] data_in;
  logic [AW-1:0] sel_r_a;
  logic [AW-1:0] sel_r_b;
  logic [DW-1:0] ra;
  logic [DW-1:0] rb;
  logic          clr_req;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .we(we), .sel_r_in(sel_r_in), .data_in(data_in),
    .sel_r_a(sel_r_a), .sel_r_b(sel_r_b), .ra(ra), .rb(rb),
    .clr_req(clr_req), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model + scoreboard ----------------
  logic [DW-1:0]     m_mem [NR];
  int                m_left;      // clear edges still to come (0 = idle)
  logic [2*DW:0]     exp_q [$];   // {busy, ra, rb} expected after each edge

  function automatic logic [DW-1:0] m_read(input int s, input bit w_en,
                                           input int w_idx, input logic [DW-1:0] w_dat);
    if (s >= NR || s == 0) return '0;
    if (BYP && w_en && w_idx == s) return w_dat;
    return m_mem[s];
  endfunction

  always @(posedge clk or negedge rst) begin
    bit            w_en;
    int            w_idx;
    logic [DW-1:0] w_dat;
    bit            was_idle;
    logic [DW-1:0] ea, eb;
    if (!rst) begin
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_left = 0;
      exp_q.delete();
    end else begin
      was_idle = (m_left == 0);
      w_en = 0; w_idx = 0; w_dat = '0;
      if (!was_idle) begin
        w_en = 1; w_idx = NR - m_left; w_dat = '0;
        m_left--;
      end else if (we && int'(sel_r_in) < NR && sel_r_in != 0) begin
        w_en = 1; w_idx = int'(sel_r_in); w_dat = data_in;
      end
      if (was_idle && clr_req) m_left = NR;
      ea = m_read(int'(sel_r_a), w_en, w_idx, w_dat);
      eb = m_read(int'(sel_r_b), w_en, w_idx, w_dat);
      if (w_en) m_mem[w_idx] = w_dat;
      exp_q.push_back({(m_left > 0), ea, eb});
    end
  end

  // Compare process: checks outputs on every falling edge.
  always @(negedge clk) begin
    logic [2*DW:0] e;
    if (!rst) begin
      n_tests++;
      if (busy !== 1'b0 || ra !== '0 || rb !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs t=%0t got busy=%b ra=%h rb=%h want all zero",
                 $time, busy, ra, rb);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({busy, ra, rb} !== e) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t got busy=%b ra=%h rb=%h want busy=%b ra=%h rb=%h",
                 $time, busy, ra, rb, e[2*DW], e[2*DW-1:DW], e[DW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic w, input logic [AW-1:0] si, input logic [DW-1:0] d,
                      input logic [AW-1:0] a, input logic [AW-1:0] b, input logic c);
    we = w; sel_r_in = si; data_in = d; sel_r_a = a; sel_r_b = b; clr_req = c;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 0; sel_r_in = '0; data_in = '0; sel_r_a = '0; sel_r_b = '0; clr_req = 0;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic drain_busy();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick(0, '0, '0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 0);
      n++;
    end
    chk("drain_busy_bounded", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ra", ra, '0);
    chk("reset_rb", rb, '0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;

    // Basic write then read one cycle later.
    tick(1, 6'd5, 32'hDEADBEEF, 6'd0, 6'd0, 0);
    tick(0, 6'd0, '0, 6'd5, 6'd7, 0);
    chk("read_entry5", ra, 32'hDEADBEEF);
    chk("read_unwritten7", rb, '0);

    // Hardwired zero register.
    tick(1, 6'd0, 32'h1234, 6'd0, 6'd0, 0);
    tick(0, 6'd0, '0, 6'd0, 6'd0, 0);
    chk("r0_reads_zero", ra, '0);

    // Out-of-range write (40 would alias entry 8 if truncated) and read.
    tick(1, 6'd40, 32'hBAD0BAD0, 6'd0, 6'd0, 0);
    tick(0, 6'd0, '0, 6'd8, 6'd40, 0);
    chk("oor_read_zero", rb, '0);
    chk("oor_no_alias_entry8", ra, '0);

    // Same-cycle write/read collision.
    tick(1, 6'd3, 32'hA5A5A5A5, 6'd3, 6'd0, 0);
    chk("collision_ra", ra, BYP ? 32'hA5A5A5A5 : 32'h0);
    tick(0, 6'd0, '0, 6'd3, 6'd0, 0);
    chk("after_collision_ra", ra, 32'hA5A5A5A5);

    // Fill 1..31 with index, then clear with a dropped write and a repeat request.
    for (int i = 1; i < NR; i++) tick(1, 6'(i), 32'(i), 6'(i - 1), 6'(i), 0);
    tick(0, '0, '0, 6'd9, 6'd31, 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick(n == 3, 6'd9, 32'hFF, 6'($urandom_range(0, 31)), 6'd9, n == 10);
    end
    chk("busy_cycles", 32'(n), 32'(NR));
    tick(0, '0, '0, 6'd9, 6'd31, 0);
    chk("cleared_entry9", ra, '0);
    chk("cleared_entry31", rb, '0);
    for (int i = 0; i < NR; i++) tick(0, '0, '0, 6'(i), 6'(NR - 1 - i), 0);

    // Same-cycle write and clear request.
    tick(1, 6'd4, 32'h77, 6'd4, 6'd0, 1);
    chk("wr_clr_same_cycle", ra, BYP ? 32'h77 : 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick(0, '0, '0, 6'd4, 6'd4, 0);
      if (k == 2) chk("entry4_before_clear", ra, 32'h77);
      if (k == 6) chk("entry4_after_clear", ra, 32'h0);
    end
    drain_busy();

    // Asynchronous reset in the middle of a clear.
    for (int i = 1; i <= 10; i++) tick(1, 6'(i + 10), $urandom, 6'd0, 6'd0, 0);
    tick(0, '0, '0, 6'd15, 6'd20, 1);
    for (int i = 0; i < 9; i++) tick(0, '0, '0, 6'd15, 6'd20, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ra", ra, '0);
    chk("async_rst_rb", rb, '0);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick(1, 6'd6, 32'hCAFE, 6'd6, 6'd15, 0);
    chk("post_rst_write_collision", ra, BYP ? 32'hCAFE : 32'h0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    tick(0, '0, '0, 6'd6, 6'd15, 0);
    chk("post_rst_write", ra, 32'hCAFE);
    chk("post_rst_entry15_zero", rb, '0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 600; i++) begin
      tick(1'($urandom_range(0, 1)), 6'($urandom_range(0, 39)), $urandom,
           6'($urandom_range(0, 39)), 6'($urandom_range(0, 63)),
           $urandom_range(0, 59) == 0);
    end
    drain_busy();
    tick(0, '0, '0, '0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the MIPS datapath: one write port, two registered read ports, and a hardware bulk-clear sequencer. It generalises width and depth, adds an optional hardwired-zero register and an optional write-to-read bypass, and sits between the decode stage (selectors) and the ALU operand muxes (`ra`/`rb`).

## Interface
Parameters:
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: selector width in bits.
- `NREGS`, default 32: implemented entries, 2..2**ADDR_W.
- `ZERO_R0`, default 1: when 1, entry 0 reads as 0 and ignores writes.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `we`, input, 1: write enable.
- `sel_r_in`, input, ADDR_W: write selector.
- `data_in`, input, DATA_W: write data.
- `sel_r_a`, input, ADDR_W: read selector, port A.
- `sel_r_b`, input, ADDR_W: read selector, port B.
- `ra`, output, DATA_W: registered read data, port A.
- `rb`, output, DATA_W: registered read data, port B.
- `clr_req`, input, 1: single-cycle request to zero all entries.
- `busy`, output, 1: clear sequence in progress.

## Operation
- Storage: NREGS × DATA_W flops. Reset (`rst` low) asynchronously zeroes every entry, `ra`, `rb`, `busy` and the clear index, and forces state IDLE.
- Write: on an edge with `we`=1, state IDLE and `sel_r_in` < NREGS, the entry takes `data_in`.
  - `sel_r_in` ≥ NREGS: write dropped.
  - `ZERO_R0`=1 with `sel_r_in`=0: write dropped.
- Read: every edge, `ra` ← entry[`sel_r_a`] and `rb` ← entry[`sel_r_b`].
  - A selector ≥ NREGS returns 0.
  - Selector 0 with `ZERO_R0`=1 returns 0.
  - Same-cycle write/read collisions follow the Configuration section.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR when `clr_req`=1. On that edge: index ← 0, `busy` ← 1.
  - In CLEAR, each edge zeroes entry[index] and increments index.
  - On the edge that clears entry NREGS-1: CLEAR → IDLE, `busy` ← 0.
- Simultaneous events:
  - `we` and `clr_req` in the same IDLE cycle: the write is performed, then the clear starts. The written entry is later zeroed.
  - `we` while in CLEAR: dropped. No write occurs during `busy`.
  - `clr_req` while in CLEAR: ignored; the sequence is not restarted.
  - Reads while in CLEAR proceed normally. Entries not yet reached keep their old value.
- Reset asserted mid-clear: immediate full zero, state IDLE, `busy`=0.

## Timing
- Write latency: data is stored at edge N. It is visible on `ra`/`rb` after edge N+1 when read at N+1, or after edge N with bypass.
- Read latency: 1 cycle. The selector is sampled at edge N and the data is valid after edge N.
- Clear: `clr_req` sampled high at edge N gives `busy`=1 after N. Entries 0..NREGS-1 are zeroed at edges N+1..N+NREGS. `busy`=0 after edge N+NREGS, so `busy` is high for exactly NREGS cycles.
- The next `we` is accepted at edge N+NREGS+1.

## Configuration
- Macro `RF_BYPASS_EN`.
  - Defined: on an edge where an entry is written, including clear-sequencer zero writes, a read port selecting that same entry registers the new value (write-first).
  - Undefined: the read port registers the pre-write value (read-first). Forwarding logic is absent.
- `ZERO_R0` and out-of-range rules take precedence in both modes.

## Test plan
- Reset, then write 0xDEADBEEF to entry 5, then read `sel_r_a`=5 next cycle: `ra`=0xDEADBEEF one cycle after the selector; `rb` of an unwritten entry 7 is 0.
- `ZERO_R0`=1, write 0x1234 to entry 0, then read it: `ra`=0. With `NREGS`=16, write to 20 and read 20: `rb`=0 and no entry is modified.
- Write 0xA5A5A5A5 to entry 3 while `sel_r_a`=3 in the same cycle: `ra`=0xA5A5A5A5 with `RF_BYPASS_EN`, or the previous value (0) without it.
- Fill entries 1..31 with their index, then pulse `clr_req`: `busy` high for exactly 32 cycles; `we` to entry 9 during `busy` is dropped; all entries read 0 afterwards; a second `clr_req` mid-sequence does not extend `busy`.
- Same-cycle `we` (entry 4, 0x77) and `clr_req`: entry 4 reads 0x77 until its clear edge (N+5), then reads 0.
- Assert `rst` low asynchronously at clear cycle 10 of 32, between edges: `busy`, `ra` and `rb` go 0 immediately; the FSM is in IDLE after release and accepts a new write on the next edge.
